conv_window_sched: RTL
======================

# conv_window_sched

Sequencer that drives the 3x3 floating-point `conv_block` across a full image. It loads the nine kernel weights once, then fetches one 3x3 window per output pixel from a single-port word memory, in raster order. It presents each window with a one-cycle valid strobe and tags each `conv_block` result with its output row and column. It sits between the image/kernel memory and `conv_block`, and produces a valid-only result stream with no backpressure.

## Interface
- `IMAGE_SIZE`, 16: square input image side; output is (IMAGE_SIZE-2)^2 positions
- `DATA_WIDTH`, 16: FP16 word width
- `ADDR_SIZE`, 9: memory address width
- `IMG_BASE`, 0: word address of image pixel (0,0); image is row-major
- `KER_BASE`, 256: word address of KerW1; KerW1..KerW9 are consecutive
- `CONV_LATENCY`, 2: cycles from `win_valid` to a valid `conv_block` sum; must be >= 1
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request; accepted only in IDLE
- `busy` out 1: high from the cycle after start is accepted until `done`
- `done` out 1: one-cycle pulse after the final `out_valid`
- `mem_rd_en` out 1: read strobe
- `mem_addr` out ADDR_SIZE: read address
- `mem_rdata` in DATA_WIDTH: read data, valid exactly 1 cycle after `mem_rd_en`
- `img_win` out 9*DATA_WIDTH: ImgP1 in bits [15:0] through ImgP9 in the MSBs; row-major window
- `ker_w` out 9*DATA_WIDTH: KerW1..KerW9, same packing
- `win_valid` out 1: `img_win` holds a new complete window
- `out_valid` out 1: `conv_block` outputs correspond to `out_row`/`out_col`
- `out_row`, `out_col` out 8: output position of the current result

## Operation
- FSM states: IDLE, LOAD_K, FETCH, LAST, DRAIN, DONE.
- **IDLE:** `start` moves to LOAD_K. Row counter r, column counter c and tap counter k are cleared.
- **LOAD_K:** 9 cycles with `mem_rd_en`=1 and addr = KER_BASE+k. Data of read k is written to ker_w slot k one cycle later. Then go to FETCH; the 9th weight is captured in the first FETCH cycle.
- **FETCH:** 9 cycles with `mem_rd_en`=1 and addr = IMG_BASE + (r + k/3)*IMAGE_SIZE + c + k%3. Returned data is written to a shadow window register, slot k, one cycle later.
- **LAST:** 1 cycle with `mem_rd_en`=0. Slot 8 is captured, the shadow is copied to `img_win` at the clock edge, and `win_valid` is registered high for the next cycle.
- **Position advance after LAST:** c++; at c = IMAGE_SIZE-3, c wraps to 0 and r++. After (r,c) = (IMAGE_SIZE-3, IMAGE_SIZE-3), go to DRAIN; otherwise go to FETCH.
- **Result tagging:** `win_valid` and (r,c) enter a CONV_LATENCY-deep tag pipeline. `out_valid`, `out_row` and `out_col` are the pipeline outputs.
- **DRAIN:** wait until the tag pipeline is empty, then go to DONE.
- **DONE:** `done`=1 for 1 cycle, `busy`=0, then IDLE. `ker_w` and `img_win` hold their values until the next start.
- `start` outside IDLE is ignored.
- Counters are unsigned; no saturation is needed because counter bounds are parameter-fixed.

## Timing
- All outputs reset to 0: FSM=IDLE, counters=0, `img_win`=0, `ker_w`=0, tag pipeline cleared.
- Reset mid-operation aborts immediately: no `done` pulse, and results in flight are discarded.
- `start` in cycle t: LOAD_K occupies cycles t+1..t+9. The first window's FETCH occupies t+10..t+18, LAST is t+19, and the first `win_valid` is at t+20.
- Window period is 10 cycles; `win_valid` is high for exactly 1 cycle per window.
- `out_valid` for a window follows its `win_valid` by exactly CONV_LATENCY cycles.
- The last `win_valid` is at t+10+10*(IMAGE_SIZE-2)^2. `done` follows the last `out_valid` by 1 cycle.
- `img_win` is stable from each `win_valid` until the next LAST edge (10 cycles), so `conv_block` sees a constant window.
- `start` coinciding with `rst`: `rst` wins.

## Structure
- Package `conv_pkg` holds:
  - the state enum
  - `KSIZE`=3 and `NTAPS`=9
  - the tap-to-(row,col) offset constants
- Sub-module `conv_win_addr_gen` is combinational: (r, c, k, mode) -> `mem_addr`.
- Tag pipeline and FSM are in the top level.

## Test plan
- **Memory model:** rdata(a) = a, zero-extended, 1-cycle latency; IMAGE_SIZE=16. Start -> ker_w = {264..256}. First `img_win` = {34,33,32,18,17,16,2,1,0}, giving ImgP1=0 and ImgP9=34, at t+20.
- **Last window:** same model -> 196 `win_valid` pulses. Last `img_win` has ImgP1=221 and ImgP9=255, with out_row=out_col=13. Between windows, out_col wraps 13 -> 0 while out_row increments.
- **Result tagging:** CONV_LATENCY=2 with `conv_block` attached, using the existing FP16 kernel 0x3C40/0x3C80/0x3D00 pattern. Each `out_valid` is exactly 2 cycles after its `win_valid`. `done` is 1 cycle after the 196th `out_valid`, and `busy` falls with it.
- **Busy protection:** `start` pulsed at t+50 while busy -> no restart; address sequence unchanged.
- **Mid-run reset:** `rst` at t+500 -> next cycle all outputs 0, IDLE. A new `start` reproduces the first scenario exactly.
- **Small image:** IMAGE_SIZE=4 -> 4 windows. Positions out (0,0), (0,1), (1,0), (1,1); `done` at t+10+40+CONV_LATENCY+1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package conv_pkg;

    localparam int KSIZE = 3;
    localparam int NTAPS = KSIZE * KSIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_FETCH,
        S_LAST,
        S_DRAIN,
        S_DONE
    } state_t;

    // Which address the generator produces this cycle
    typedef enum logic [1:0] {
        AM_NONE,
        AM_KER,
        AM_IMG
    } addr_mode_t;

    // Row-major tap k sits at (k / 3, k % 3) inside the window; 2 bits per tap, tap 0 in the LSBs
    localparam logic [2*NTAPS-1:0] TAP_ROW_OFS = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    localparam logic [2*NTAPS-1:0] TAP_COL_OFS = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] tap_row(input logic [3:0] k);
        return TAP_ROW_OFS[2*k +: 2];
    endfunction

    function automatic logic [1:0] tap_col(input logic [3:0] k);
        return TAP_COL_OFS[2*k +: 2];
    endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Maps (window row, window col, tap, mode) to a word address for the kernel or image region.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module conv_win_addr_gen
    import conv_pkg::*;
#(
    parameter int IMAGE_SIZE = 16,
    parameter int ADDR_SIZE  = 9,
    parameter int IMG_BASE   = 0,
    parameter int KER_BASE   = 256
) (
    input  logic [7:0]           row,
    input  logic [7:0]           col,
    input  logic [3:0]           tap,
    input  addr_mode_t           mode,
    output logic [ADDR_SIZE-1:0] addr
);

    logic [ADDR_SIZE-1:0] img_row;
    logic [ADDR_SIZE-1:0] img_col;

    // Address select; idle cycles park the bus at 0
    always_comb begin
        img_row = ADDR_SIZE'(row) + ADDR_SIZE'(tap_row(tap));
        img_col = ADDR_SIZE'(col) + ADDR_SIZE'(tap_col(tap));
        addr    = '0;
        case (mode)
            AM_KER:  addr = ADDR_SIZE'(KER_BASE) + ADDR_SIZE'(tap);
            AM_IMG:  addr = ADDR_SIZE'(IMG_BASE) + img_row * ADDR_SIZE'(IMAGE_SIZE) + img_col;
            default: addr = '0;
        endcase
    end

endmodule

// File: rtl/conv_window_sched.sv
// Loads 9 kernel weights once, then fetches one 3x3 window per output pixel in raster order and tags conv results.
// Latency: first win_valid 20 cycles after start, one window per 10 cycles; out_valid trails win_valid by CONV_LATENCY.
// Backpressure: none; fixed-latency memory reads and a valid-only result stream.
module conv_window_sched
    import conv_pkg::*;
#(
    parameter int IMAGE_SIZE   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_SIZE    = 9,
    parameter int IMG_BASE     = 0,
    parameter int KER_BASE     = 256,
    parameter int CONV_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_rd_en,
    output logic [ADDR_SIZE-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic [NTAPS*DATA_WIDTH-1:0] img_win,
    output logic [NTAPS*DATA_WIDTH-1:0] ker_w,
    output logic                        win_valid,
    output logic                        out_valid,
    output logic [7:0]                  out_row,
    output logic [7:0]                  out_col
);

    localparam int LAST_POS = IMAGE_SIZE - 3;

    state_t     state_q, state_d;
    addr_mode_t addr_mode;
    logic [7:0] r_q, c_q;
    logic [3:0] k_q;
    logic       last_tap, at_end, drain_empty;

    logic       rd_vld_q, rd_ker_q;
    logic [3:0] rd_tap_q;
    logic [NTAPS*DATA_WIDTH-1:0] shadow_q, img_win_q, ker_w_q;

    logic                           win_valid_q;
    logic [7:0]                     win_row_q, win_col_q;
    logic [CONV_LATENCY-1:0]        pipe_vld_q, pipe_inner;
    logic [CONV_LATENCY-1:0][7:0]   pipe_row_q, pipe_col_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state outputs
    always_comb begin
        state_d    = state_q;
        mem_rd_en  = 1'b0;
        addr_mode  = AM_NONE;
        busy       = 1'b0;
        done       = 1'b0;
        last_tap   = (k_q == 4'(NTAPS - 1));
        at_end     = (r_q == 8'(LAST_POS)) && (c_q == 8'(LAST_POS));
        // The output stage may still hold the final result; DONE lands right after it
        pipe_inner = pipe_vld_q;
        pipe_inner[CONV_LATENCY-1] = 1'b0;
        drain_empty = !win_valid_q && (pipe_inner == '0);
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_K;
            end
            S_LOAD_K: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                addr_mode = AM_KER;
                if (last_tap) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                addr_mode = AM_IMG;
                if (last_tap) state_d = S_LAST;
            end
            S_LAST: begin
                busy    = 1'b1;
                state_d = at_end ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_empty) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Row/column/tap counters: tap steps every read cycle, position advances on LAST
    always_ff @(posedge clk) begin
        if (rst || state_q == S_IDLE) begin
            r_q <= '0;
            c_q <= '0;
            k_q <= '0;
        end else if (state_q == S_LOAD_K || state_q == S_FETCH) begin
            k_q <= last_tap ? 4'd0 : k_q + 4'd1;
        end else if (state_q == S_LAST && !at_end) begin
            if (c_q == 8'(LAST_POS)) begin
                c_q <= '0;
                r_q <= r_q + 8'd1;
            end else begin
                c_q <= c_q + 8'd1;
            end
        end
    end

    conv_win_addr_gen #(
        .IMAGE_SIZE (IMAGE_SIZE),
        .ADDR_SIZE  (ADDR_SIZE),
        .IMG_BASE   (IMG_BASE),
        .KER_BASE   (KER_BASE)
    ) u_addr_gen (
        .row  (r_q),
        .col  (c_q),
        .tap  (k_q),
        .mode (addr_mode),
        .addr (mem_addr)
    );

    // Capture read data one cycle after each read; publish the window on LAST including the in-flight tap 8
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_ker_q  <= 1'b0;
            rd_tap_q  <= '0;
            ker_w_q   <= '0;
            shadow_q  <= '0;
            img_win_q <= '0;
        end else begin
            rd_vld_q <= mem_rd_en;
            rd_ker_q <= (state_q == S_LOAD_K);
            rd_tap_q <= k_q;
            if (rd_vld_q) begin
                if (rd_ker_q) ker_w_q[rd_tap_q*DATA_WIDTH +: DATA_WIDTH]  <= mem_rdata;
                else          shadow_q[rd_tap_q*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            end
            if (state_q == S_LAST)
                img_win_q <= {mem_rdata, shadow_q[(NTAPS-1)*DATA_WIDTH-1:0]};
        end
    end

    // Tag pipeline: win_valid and its position travel CONV_LATENCY stages alongside conv_block
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_row_q  <= '0;
            pipe_col_q  <= '0;
        end else begin
            win_valid_q <= (state_q == S_LAST);
            if (state_q == S_LAST) begin
                win_row_q <= r_q;
                win_col_q <= c_q;
            end
            pipe_vld_q[0] <= win_valid_q;
            pipe_row_q[0] <= win_row_q;
            pipe_col_q[0] <= win_col_q;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_row_q[i] <= pipe_row_q[i-1];
                pipe_col_q[i] <= pipe_col_q[i-1];
            end
        end
    end

    assign img_win   = img_win_q;
    assign ker_w     = ker_w_q;
    assign win_valid = win_valid_q;
    assign out_valid = pipe_vld_q[CONV_LATENCY-1];
    assign out_row   = pipe_row_q[CONV_LATENCY-1];
    assign out_col   = pipe_col_q[CONV_LATENCY-1];

endmodule
